// File: rtl/motor_pkg.sv
// motor_pkg: shared constants for the motor move scheduler slice.
//   NUM_MOTORS / POS_W / MOTOR_IDX_W : axis count, position width, index width
//   DIR_SETUP / SETUP_W              : direction-setup hold and its counter width
//   INIT_ALL                         : init_done value that enables arbitration
//   ST_*                             : scheduler FSM state encodings
//   slice_pos()                      : pulls one motor's field out of a flat bus
package motor_pkg;

  localparam int NUM_MOTORS  = 6;
  localparam int POS_W       = 10;
  localparam int MOTOR_IDX_W = 3;
  localparam int DIR_SETUP   = 4;
  localparam int SETUP_W     = $clog2(DIR_SETUP + 1);

  localparam logic [NUM_MOTORS-1:0] INIT_ALL = 6'h3F;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CALC  = 3'd1;
  localparam logic [2:0] ST_SETUP = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  function automatic logic [POS_W-1:0] slice_pos(
    input logic [NUM_MOTORS*POS_W-1:0] bus,
    input logic [MOTOR_IDX_W-1:0]      k
  );
    return bus[int'(k)*POS_W +: POS_W];
  endfunction

endpackage

// File: rtl/rr_arbiter6.sv
// rr_arbiter6: combinational round-robin picker for six requesters.
//   req   : request vector
//   ptr   : highest-priority index this round (0..5)
//   grant : one-hot grant
//   idx   : binary index of the grant
//   valid : at least one request present
module rr_arbiter6
  import motor_pkg::*;
(
  input  logic [NUM_MOTORS-1:0]  req,
  input  logic [MOTOR_IDX_W-1:0] ptr,
  output logic [NUM_MOTORS-1:0]  grant,
  output logic [MOTOR_IDX_W-1:0] idx,
  output logic                   valid
);

  logic [MOTOR_IDX_W:0]   sum;
  logic [MOTOR_IDX_W-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest request to ptr
  // (ascending, wrapping) is the one left standing.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int off = NUM_MOTORS - 1; off >= 0; off--) begin
      sum  = {1'b0, ptr} + 4'(off);
      cand = (sum >= 4'(NUM_MOTORS)) ? 3'(sum - 4'(NUM_MOTORS)) : sum[MOTOR_IDX_W-1:0];
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    if (valid) grant = NUM_MOTORS'(1) << idx;
  end

endmodule

// File: rtl/motor_move_scheduler.sv
// motor_move_scheduler: serialises point-to-point moves from six axes onto a
// single shared pulse generator.
//   clk, rst (async, active-low)
//   init_done[5:0]   : all ones required before any request is arbitrated
//   req / target     : per-motor request and flat 10-bit targets
//   ack / done       : one-hot, one-cycle accept and completion strobes
//   pg_start / pg_pulse_num / pg_motor / pg_busy : pulse generator handshake
//   dr / pos         : per-motor direction and current position
//   sched_busy       : scheduler not idle
module motor_move_scheduler
  import motor_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MOTORS-1:0]         init_done,
  input  logic [NUM_MOTORS-1:0]         req,
  input  logic [NUM_MOTORS*POS_W-1:0]   target,
  output logic [NUM_MOTORS-1:0]         ack,
  output logic [NUM_MOTORS-1:0]         done,
  output logic                          pg_start,
  output logic [POS_W-1:0]              pg_pulse_num,
  output logic [MOTOR_IDX_W-1:0]        pg_motor,
  input  logic                          pg_busy,
  output logic [NUM_MOTORS-1:0]         dr,
  output logic [NUM_MOTORS*POS_W-1:0]   pos,
  output logic                          sched_busy
);

  logic [2:0]             state_q, state_d;
  logic [MOTOR_IDX_W-1:0] ptr_q, ptr_d;
  logic [MOTOR_IDX_W-1:0] g_q, g_d;
  logic [NUM_MOTORS-1:0]  g_oh_q, g_oh_d;
  logic [POS_W-1:0]       tgt_q, tgt_d;
  logic [NUM_MOTORS-1:0]  dr_q, dr_d;
  logic [POS_W-1:0]       pos_q [NUM_MOTORS];
  logic [POS_W-1:0]       pos_d [NUM_MOTORS];
  logic [POS_W-1:0]       pulse_q, pulse_d;
  logic [MOTOR_IDX_W-1:0] motor_q, motor_d;
  logic [SETUP_W-1:0]     cnt_q, cnt_d;
  logic                   run_first_q, run_first_d;

  logic [NUM_MOTORS-1:0]  arb_grant;
  logic [MOTOR_IDX_W-1:0] arb_idx;
  logic                   arb_valid;

  logic [POS_W-1:0]       cur_pos;
  logic [POS_W-1:0]       delta;
  logic                   newdir;

  rr_arbiter6 u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign cur_pos = pos_q[g_q];
  assign newdir  = tgt_q < cur_pos;
  assign delta   = newdir ? (cur_pos - tgt_q) : (tgt_q - cur_pos);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    g_oh_d      = g_oh_q;
    tgt_d       = tgt_q;
    dr_d        = dr_q;
    pos_d       = pos_q;
    pulse_d     = pulse_q;
    motor_d     = motor_q;
    cnt_d       = cnt_q;
    run_first_d = run_first_q;

    case (state_q)
      ST_IDLE: begin
        if (init_done == INIT_ALL && arb_valid) begin
          g_d     = arb_idx;
          g_oh_d  = arb_grant;
          tgt_d   = slice_pos(target, arb_idx);
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        ptr_d = (g_q == MOTOR_IDX_W'(NUM_MOTORS - 1)) ? '0 : g_q + 3'd1;
        if (delta == '0) begin
          state_d = ST_DONE;
        end else begin
          // Pulse count and motor are loaded here so they are already
          // valid on the pg_start cycle.
          dr_d[g_q] = newdir;
          pulse_d   = delta;
          motor_d   = g_q;
          cnt_d     = '0;
          state_d   = (newdir != dr_q[g_q]) ? ST_SETUP : ST_START;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_W'(DIR_SETUP - 1)) state_d = ST_START;
        else                                   cnt_d   = cnt_q + 1'b1;
      end
      ST_START: begin
        run_first_d = 1'b1;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        // The generator gets one cycle to raise pg_busy after pg_start.
        run_first_d = 1'b0;
        if (!run_first_q && !pg_busy) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Position commits on entry to DONE so it is current while done is high.
    if (state_d == ST_DONE) pos_d[g_q] = tgt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      g_q         <= '0;
      g_oh_q      <= '0;
      tgt_q       <= '0;
      dr_q        <= '0;
      pulse_q     <= '0;
      motor_q     <= '0;
      cnt_q       <= '0;
      run_first_q <= 1'b0;
      for (int i = 0; i < NUM_MOTORS; i++) pos_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      g_q         <= g_d;
      g_oh_q      <= g_oh_d;
      tgt_q       <= tgt_d;
      dr_q        <= dr_d;
      pulse_q     <= pulse_d;
      motor_q     <= motor_d;
      cnt_q       <= cnt_d;
      run_first_q <= run_first_d;
      pos_q       <= pos_d;
    end
  end

  assign ack          = (state_q == ST_CALC) ? g_oh_q : '0;
  assign done         = (state_q == ST_DONE) ? g_oh_q : '0;
  assign pg_start     = (state_q == ST_START);
  assign pg_pulse_num = pulse_q;
  assign pg_motor     = motor_q;
  assign dr           = dr_q;
  assign sched_busy   = (state_q != ST_IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MOTORS; gi++) begin : g_pos
      assign pos[gi*POS_W +: POS_W] = pos_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_motor_move_scheduler.sv
module tb_motor_move_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  init_done;
  logic [5:0]  req;
  logic [59:0] target;
  logic [5:0]  ack;
  logic [5:0]  done;
  logic        pg_start;
  logic [9:0]  pg_pulse_num;
  logic [2:0]  pg_motor;
  logic        pg_busy;
  logic [5:0]  dr;
  logic [59:0] pos;
  logic        sched_busy;

  int n_assert = 0;
  int n_fail   = 0;
  int rr_exp [5] = '{0, 1, 5, 0, 1};

  always #5 clk = ~clk;

  motor_move_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .init_done    (init_done),
    .req          (req),
    .target       (target),
    .ack          (ack),
    .done         (done),
    .pg_start     (pg_start),
    .pg_pulse_num (pg_pulse_num),
    .pg_motor     (pg_motor),
    .pg_busy      (pg_busy),
    .dr           (dr),
    .pos          (pos),
    .sched_busy   (sched_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse generator model: busy for pg_pulse_num cycles after a pg_start.
  initial begin
    pg_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (pg_start === 1'b1) begin
        pg_busy = 1'b1;
        repeat (int'(pg_pulse_num)) @(negedge clk);
        pg_busy = 1'b0;
      end
    end
  end

  initial begin
    int got [5];
    int nack;
    int ndone;
    int starts;
    int bad;
    int cnt;
    int gidx;
    logic [5:0] last_ack;

    nack = 0; ndone = 0; starts = 0; last_ack = '0;
    for (int i = 0; i < 5; i++) got[i] = -1;

    // Reset state
    rst = 1'b0; init_done = '0; req = '0; target = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 6'h00);
    check("rst_done", done, 6'h00);
    check("rst_pg_start", pg_start, 1'b0);
    check("rst_pulse_num", pg_pulse_num, 10'd0);
    check("rst_pg_motor", pg_motor, 3'd0);
    check("rst_pos", pos, 60'd0);
    check("rst_dr", dr, 6'h00);
    check("rst_busy", sched_busy, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    $display("reset released: sched_busy=%0b", sched_busy);

    // Round robin: zero-delta moves, req held
    init_done = 6'h3F;
    req = 6'b100011;
    for (int c = 0; c < 60 && ndone < 5; c++) begin
      @(negedge clk);
      if (pg_start) starts++;
      if (ack != 0) begin
        gidx = -1;
        for (int b = 0; b < 6; b++) if (ack[b]) gidx = b;
        check("rr_prev_done_before_ack", nack, ndone);
        check("rr_no_done_with_ack", done, 6'h00);
        if (nack < 5) got[nack] = gidx;
        nack++;
        last_ack = ack;
        $display("rr ack: motor %0d", gidx);
      end
      if (done != 0) begin
        check("rr_done_matches_ack", done, last_ack);
        ndone++;
        if (ndone == 5) req = '0;
      end
    end
    check("rr_done_count", ndone, 5);
    for (int i = 0; i < 5; i++) check("rr_order", got[i], rr_exp[i]);
    check("rr_no_pg_start", starts, 0);
    @(negedge clk);

    // Init gating
    init_done = 6'h1F;
    req = 6'b000001;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (ack != 0 || sched_busy) bad++;
    end
    check("gate_no_ack", bad, 0);
    init_done = 6'h3F;
    @(negedge clk);
    check("gate_ack0", ack, 6'b000001);
    req = '0;
    @(negedge clk);
    check("gate_done0", done, 6'b000001);
    $display("init gating: ack after init_done=3F");
    @(negedge clk);

    // Single move: motor 2, 0 -> 300, no direction change
    target[20 +: 10] = 10'd300;
    req = 6'b000100;
    @(negedge clk);
    check("m1_ack", ack, 6'b000100);
    req = '0;
    @(negedge clk);
    check("m1_pg_start", pg_start, 1'b1);
    check("m1_pulse_num", pg_pulse_num, 10'd300);
    check("m1_pg_motor", pg_motor, 3'd2);
    check("m1_dr", dr, 6'b000000);
    cnt = 0;
    while (done == 0 && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    check("m1_done_latency", cnt, 301);
    check("m1_done", done, 6'b000100);
    @(negedge clk);
    check("m1_pos", pos[20 +: 10], 10'd300);
    check("m1_idle", sched_busy, 1'b0);
    $display("move1: motor 2 pos=%0d", pos[20 +: 10]);

    // Direction change: motor 2, 300 -> 100
    target[20 +: 10] = 10'd100;
    req = 6'b000100;
    @(negedge clk);
    check("m2_ack", ack, 6'b000100);
    check("m2_dr_in_calc", dr[2], 1'b0);
    req = '0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (dr[2] !== 1'b1 || pg_start !== 1'b0) bad++;
    end
    check("m2_setup_hold", bad, 0);
    @(negedge clk);
    check("m2_pg_start", pg_start, 1'b1);
    check("m2_pulse_num", pg_pulse_num, 10'd200);
    cnt = 0;
    while (done == 0 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check("m2_done_latency", cnt, 201);
    check("m2_done", done, 6'b000100);
    @(negedge clk);
    check("m2_pos", pos[20 +: 10], 10'd100);
    $display("move2: motor 2 pos=%0d dr=%0b", pos[20 +: 10], dr[2]);

    // Zero delta: motor 4 target equals pos
    target[40 +: 10] = 10'd0;
    req = 6'b010000;
    @(negedge clk);
    check("z_ack", ack, 6'b010000);
    check("z_no_start_a", pg_start, 1'b0);
    req = '0;
    @(negedge clk);
    check("z_done", done, 6'b010000);
    check("z_no_start_b", pg_start, 1'b0);
    check("z_dr", dr, 6'b000100);
    $display("zero delta: motor 4 done");
    @(negedge clk);

    // Reset mid-run: motor 3, 0 -> 100
    target[30 +: 10] = 10'd100;
    req = 6'b001000;
    @(negedge clk);
    check("r_ack", ack, 6'b001000);
    req = '0;
    @(negedge clk);
    check("r_pg_start", pg_start, 1'b1);
    check("r_pulse_num", pg_pulse_num, 10'd100);
    check("r_pg_motor", pg_motor, 3'd3);
    repeat (10) @(negedge clk);
    check("r_running", sched_busy, 1'b1);
    rst = 1'b0;
    #1;
    check("r_pg_start_low", pg_start, 1'b0);
    check("r_busy_low", sched_busy, 1'b0);
    check("r_pos_clear", pos, 60'd0);
    check("r_dr_clear", dr, 6'h00);
    check("r_pulse_clear", pg_pulse_num, 10'd0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done != 0) bad++;
    end
    rst = 1'b1;
    repeat (120) begin
      @(negedge clk);
      if (done != 0 || sched_busy) bad++;
    end
    check("r_no_done", bad, 0);
    $display("reset mid-run: scheduler idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_move_scheduler.md
Name: motor_move_scheduler

Overview:
- Sequences point-to-point move commands from six motor-axis requesters onto the single shared pulse generator (PulseSign).
- Arbitrates between requesters round-robin, computes pulse count and direction against a per-motor position register, and honours a direction-setup delay.
- Runs the start/busy handshake with the pulse generator and reports completion per motor.
- Sits between the host/command decoder and PulseSign, replacing ad-hoc per-cycle sampling with an explicit command/ack protocol.

Parameters:
- NUM_MOTORS, 6: number of requesters/axes; pointer width 3.
- POS_W, 10: position/target and pulse-count width.
- DIR_SETUP, 4: cycles DR must be stable before pg_start when a direction bit changes (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- init_done  in  6  per-axis homing complete; scheduling blocked unless all ones
- req  in  6  per-motor move request; held high, with target stable, until ack
- target  in  60  flat targets, motor k at bits [10k+9:10k]
- ack  out  6  one-hot, one-cycle: command accepted, target latched
- done  out  6  one-hot, one-cycle: move finished, position updated
- pg_start  out  1  one-cycle launch strobe to pulse generator
- pg_pulse_num  out  10  pulse count, valid and stable from pg_start until the run ends
- pg_motor  out  3  selected motor index, stable during the run
- pg_busy  in  1  pulse generator running
- dr  out  6  direction per motor: 1 = reverse (target < pos), 0 = forward
- pos  out  60  current position per motor, flat as target
- sched_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, async): state IDLE, rr pointer=0; all pos=0, dr=0, ack=0, done=0, pg_start=0, pg_pulse_num=0, pg_motor=0.
- IDLE:
  - Arbitration only when init_done==6'h3F and |req.
  - Round-robin grant: first asserted req starting at pointer p, ascending, wrapping 5→0.
  - Latch grant index g and target[g]; go CALC.
  - req is ignored while init_done is not all ones.
- CALC (1 cycle):
  - ack[g]=1.
  - delta = |target−pos[g]| in unsigned POS_W arithmetic, no overflow possible.
  - newdir = target<pos[g]. dr is unchanged when delta==0.
  - Pointer ← (g+1) mod 6.
  - Next state: DONE if delta==0; otherwise SETUP if newdir≠dr[g]; otherwise START.
  - dr[g] updates on CALC exit whenever delta≠0.
- SETUP: hold for exactly DIR_SETUP cycles with dr[g] already at its new value, then go START.
- START (1 cycle): pg_start=1, pg_pulse_num=delta, pg_motor=g; go RUN.
- RUN:
  - pg_busy is ignored in the first RUN cycle; the generator must raise it by then.
  - From the second RUN cycle, pg_busy==0 → DONE.
- DONE (1 cycle): done[g]=1, pos[g] ← latched target; go IDLE.
- Latency:
  - req sampled at T → ack at T+1 → pg_start at T+2 (same dir) or T+2+DIR_SETUP (dir change).
  - Zero-delta move: done at T+2.
- Requests arriving while sched_busy=1 wait. A requester whose req drops before ack is never granted. A target change after ack has no effect on the current move.
- init_done dropping mid-move does not abort the move; it only blocks the next arbitration.
- Async reset mid-run: everything is cleared immediately and pg_start is held 0. The pulse generator has its own reset; positions restart at 0, so re-homing is required.
- ack and done are never both set in the same cycle. At most one bit of ack or done is set in any cycle.

Decomposition:
- Shared package (motor_pkg): NUM_MOTORS, POS_W, MOTOR_IDX_W=3, INIT_ALL=6'h3F, the state enum (IDLE, CALC, SETUP, START, RUN, DONE), and the flat-bus slice helper.
- One natural sub-module: rr_arbiter6. Inputs are the request vector and pointer; outputs are the one-hot grant, the index, and valid. It is purely combinational, and the pointer register stays in the parent.

Test Plan:
- Single move: init_done=3F, req[2] with target 300 from pos 0 → ack[2] at T+1; pg_start at T+2+4 (dr[2] 0→0, so no setup → actually T+2); pg_pulse_num=300, pg_motor=2, dr[2]=0; busy model 300 cycles → done[2], pos[2]=300.
- Direction change: after the move above, req[2] target 100 → dr[2]=1 from the CALC exit; pg_start exactly 4 cycles later; pulse_num=200; pos[2]=100.
- Zero delta: req[4] target 0 with pos[4]=0 → ack[4] at T+1, done[4] at T+2, no pg_start, dr[4] unchanged.
- Round robin: req=6'b100011 held continuously → grant order 0,1,5,0,1; each ack is followed by its done before the next ack.
- Init gating: init_done=6'h1F with req[0] high for 50 cycles → no ack. Set init_done=3F → ack[0] on the following cycle.
- Reset mid-RUN: rst low during the 100-pulse run of motor 3 → pg_start=0 and sched_busy=0 immediately; pos and dr all 0; no done issued.
